// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data) arbiter for a single shared memory port,
// with a BUSY timeout abort. Define ARB_RR_EN for round-robin instead of fixed D priority.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_rnw,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_valid,
    output logic              m_rnw,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              err
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic             d_wins;
    logic             busy_end;
    logic             timeout_hit;

`ifdef ARB_RR_EN
    // Set when D was granted most recently; on contention the other side wins.
    logic last_d;

    assign d_wins = d_req && (!i_req || !last_d);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_d <= 1'b0;
        end else if (d_gnt) begin
            last_d <= 1'b1;
        end else if (i_gnt) begin
            last_d <= 1'b0;
        end
    end
`else
    assign d_wins = d_req;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        i_gnt       = 1'b0;
        d_gnt       = 1'b0;
        busy_end    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (d_wins) begin
                    d_gnt    = 1'b1;
                    state_nx = BUSY_D;
                end else if (i_req) begin
                    i_gnt    = 1'b1;
                    state_nx = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                // A ready arriving in the last allowed cycle still completes normally.
                if (m_ready) begin
                    busy_end = 1'b1;
                    state_nx = IDLE;
                end else if (cnt == CNT_LAST) begin
                    busy_end    = 1'b1;
                    timeout_hit = 1'b1;
                    state_nx    = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid <= 1'b0;
            m_rnw   <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            cnt     <= '0;
            i_done  <= 1'b0;
            d_done  <= 1'b0;
            err     <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            i_done <= busy_end && (state == BUSY_I);
            d_done <= busy_end && (state == BUSY_D);
            err    <= timeout_hit;

            if (d_gnt) begin
                m_valid <= 1'b1;
                m_rnw   <= d_rnw;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
                cnt     <= '0;
            end else if (i_gnt) begin
                m_valid <= 1'b1;
                m_rnw   <= 1'b1;
                m_addr  <= i_addr;
                m_wdata <= '0;
                cnt     <= '0;
            end else if (busy_end) begin
                m_valid <= 1'b0;
            end else if (state != IDLE) begin
                cnt <= cnt + 1'b1;
            end

            if ((state == BUSY_I) && m_ready && m_rnw) begin
                i_rdata <= m_rdata;
            end
            if ((state == BUSY_D) && m_ready && m_rnw) begin
                d_rdata <= m_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected grants, memory requests
// and completions; independent monitors pop and compare on the falling clock edge.
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          i_req, d_req, d_rnw, m_ready;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, m_rdata;
    logic          i_gnt, i_done, d_gnt, d_done, m_valid, m_rnw, err;
    logic [DW-1:0] i_rdata, d_rdata, m_wdata;
    logic [AW-1:0] m_addr;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_rnw(d_rnw), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_rnw(m_rnw), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit who; int cyc; } gnt_t;
    typedef struct { bit rnw; logic [AW-1:0] addr; logic [DW-1:0] wdata; int cyc; int len; } mem_t;
    typedef struct { bit who; bit err; int cyc; logic [DW-1:0] i_rd; logic [DW-1:0] d_rd; } done_t;

    gnt_t  gnt_q[$];
    mem_t  mem_q[$];
    done_t done_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: who was served last and what each requester's read data should be.
    bit            last_d_m = 1'b0;
    logic [DW-1:0] i_rd_m   = '0;
    logic [DW-1:0] d_rd_m   = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors
    mem_t cur;
    bit   in_txn = 1'b0;
    bit   prev_valid = 1'b0;
    int   vcnt = 0;

    always @(negedge clk) begin
        if (!reset) begin
            in_txn = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (i_gnt && d_gnt) check("both_gnt", 1, 0);
            if (i_gnt || d_gnt) begin
                if (gnt_q.size() == 0) check("unexpected_gnt", {i_gnt, d_gnt}, 0);
                else begin
                    gnt_t g;
                    g = gnt_q.pop_front();
                    check("gnt_who", d_gnt, g.who);
                    check("gnt_cyc", cyc, g.cyc);
                end
            end

            if (m_valid && !prev_valid) begin
                if (mem_q.size() == 0) check("unexpected_mvalid", 1, 0);
                else begin
                    cur = mem_q.pop_front();
                    in_txn = 1'b1;
                    vcnt = 0;
                    check("mvalid_cyc", cyc, cur.cyc);
                end
            end
            if (m_valid && in_txn) begin
                vcnt++;
                check("m_addr", m_addr, cur.addr);
                check("m_rnw", m_rnw, cur.rnw);
                check("m_wdata", m_wdata, cur.wdata);
            end
            if (!m_valid && prev_valid && in_txn) begin
                if (cur.len >= 0) check("mvalid_len", vcnt, cur.len);
                in_txn = 1'b0;
            end
            prev_valid = m_valid;

            if (i_done || d_done || err) begin
                if (done_q.size() == 0) check("unexpected_done", {i_done, d_done, err}, 0);
                else begin
                    done_t e;
                    e = done_q.pop_front();
                    check("done_who", {i_done, d_done}, e.who ? 2'b01 : 2'b10);
                    check("done_err", err, e.err);
                    check("done_cyc", cyc, e.cyc);
                    check("i_rdata", i_rdata, e.i_rd);
                    check("d_rdata", d_rdata, e.d_rd);
                end
            end
        end
    end

    // One transaction; called just after a rising edge, returns in the completion cycle.
    task automatic do_txn(input bit ir, input bit dr, input logic [AW-1:0] ia, input logic [AW-1:0] da,
                          input bit drnw, input logic [DW-1:0] dwd, input int lat, input bit tmo,
                          input logic [DW-1:0] rd, input bit keep);
        bit    win_d;
        int    c0;
        gnt_t  g;
        mem_t  m;
        done_t d;
        win_d = dr && (!ir || !RR || !last_d_m);
        last_d_m = win_d;
        c0 = cyc;
        g.who = win_d; g.cyc = c0;
        gnt_q.push_back(g);
        m.rnw   = win_d ? drnw : 1'b1;
        m.addr  = win_d ? da : ia;
        m.wdata = win_d ? dwd : '0;
        m.cyc   = c0 + 1;
        m.len   = tmo ? TMO : lat + 1;
        mem_q.push_back(m);
        if (!tmo && m.rnw) begin
            if (win_d) d_rd_m = rd;
            else       i_rd_m = rd;
        end
        d.who = win_d; d.err = tmo;
        d.cyc = c0 + (tmo ? TMO + 1 : lat + 2);
        d.i_rd = i_rd_m; d.d_rd = d_rd_m;
        done_q.push_back(d);

        i_req = ir; d_req = dr; i_addr = ia; d_addr = da; d_rnw = drnw; d_wdata = dwd;
        @(posedge clk); #1;
        if (!keep) begin
            i_req = 1'b0;
            d_req = 1'b0;
        end
        i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; d_rnw = $urandom_range(0, 1);
        if (tmo) begin
            repeat (TMO) begin
                m_ready = 1'b0; m_rdata = $urandom;
                @(posedge clk); #1;
            end
        end else begin
            repeat (lat) begin
                m_ready = 1'b0; m_rdata = $urandom;
                @(posedge clk); #1;
            end
            m_ready = 1'b1; m_rdata = rd;
            @(posedge clk); #1;
            m_ready = 1'b0; m_rdata = $urandom;
        end
    endtask

    task automatic idle_gap(input int n, input bit stray);
        i_req = 1'b0; d_req = 1'b0;
        repeat (n) begin
            m_ready = stray ? 1'b1 : 1'($urandom_range(0, 1));
            m_rdata = $urandom;
            @(posedge clk); #1;
        end
        m_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_rnw = 1'b0; m_ready = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_rnw", m_rnw, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_wdata", m_wdata, 0);
        check("rst_dones", {i_done, d_done, err}, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_gnts", {i_gnt, d_gnt}, 0);
        reset = 1'b1;

        // Contention from reset: fixed gives D,D,D,D; round-robin gives D,I,D,I.
        for (int k = 0; k < 4; k++)
            do_txn(1, 1, 32'h1000 + k, 32'h2000 + k, 1, '0, 0, 0, 32'hA000 + k, k < 3);

        // Fetch read at minimum latency.
        do_txn(1, 0, 32'h100, '0, 1, '0, 0, 0, 32'hDEADBEEF, 0);
        // Data write with ready delayed 3 cycles (last cycle before timeout).
        do_txn(0, 1, '0, 32'h200, 0, 32'h1234, 3, 0, 32'h55AA55AA, 0);
        // Timeouts on both sides, each followed by a normal transaction.
        do_txn(0, 1, '0, 32'h300, 1, 32'h0, 0, 1, 32'hBAD0BAD0, 0);
        do_txn(0, 1, '0, 32'h304, 1, 32'h0, 1, 0, 32'h600D600D, 0);
        do_txn(1, 0, 32'h400, '0, 0, '0, 0, 1, 32'hBAD1BAD1, 0);
        do_txn(1, 0, 32'h404, '0, 0, '0, 2, 0, 32'h13579BDF, 0);

        // Stray ready in IDLE must be ignored.
        idle_gap(3, 1);
        check("stray_i_rdata", i_rdata, i_rd_m);
        check("stray_d_rdata", d_rdata, d_rd_m);
        check("stray_m_valid", m_valid, 0);

        // Reset while a data read is in flight: abandoned, no done pulse.
        begin
            gnt_t g;
            mem_t m;
            g.who = 1'b1; g.cyc = cyc;
            gnt_q.push_back(g);
            m.rnw = 1'b1; m.addr = 32'h500; m.wdata = 32'h77; m.cyc = cyc + 1; m.len = -1;
            mem_q.push_back(m);
            d_req = 1'b1; d_rnw = 1'b1; d_addr = 32'h500; d_wdata = 32'h77;
            @(posedge clk); #1;
            d_req = 1'b0;
            @(posedge clk); #1;
            reset = 1'b0;
            m_ready = 1'b1;
            #1;
            check("rstmid_m_valid", m_valid, 0);
            check("rstmid_d_done", d_done, 0);
            check("rstmid_d_rdata", d_rdata, 0);
            last_d_m = 1'b0; i_rd_m = '0; d_rd_m = '0;
            @(posedge clk); #1;
            m_ready = 1'b0;
            @(posedge clk); #1;
            reset = 1'b1;
        end
        do_txn(1, 1, 32'h600, 32'h604, 1, '0, 0, 0, 32'hCAFEF00D, 0);

        // Randomised traffic.
        for (int n = 0; n < 150; n++) begin
            bit ir, dr;
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            if (!ir && !dr) ir = 1'b1;
            do_txn(ir, dr, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom,
                   $urandom_range(0, 3), ($urandom_range(0, 7) == 0), $urandom, 0);
            if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 3), 0);
        end

        idle_gap(4, 0);
        check("gnt_q_empty", gnt_q.size(), 0);
        check("mem_q_empty", mem_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);
        check("final_i_rdata", i_rdata, i_rd_m);
        check("final_d_rdata", d_rdata, d_rd_m);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, width of all address buses.
REQ-002 Parameter DATA_W, default 32, width of all data buses.
REQ-003 Parameter TIMEOUT, default 255, maximum BUSY cycles allowed before an abort.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 i_req  input  1  instruction-fetch requester wants one read.
REQ-007 i_addr  input  ADDR_W  fetch address.
REQ-008 i_gnt  output  1  fetch request accepted this cycle.
REQ-009 i_done  output  1  one-cycle pulse marking fetch completion.
REQ-010 i_rdata  output  DATA_W  fetch read data.
REQ-011 d_req  input  1  data requester wants one access.
REQ-012 d_rnw  input  1  data access direction: 1 = read, 0 = write.
REQ-013 d_addr  input  ADDR_W  data address.
REQ-014 d_wdata  input  DATA_W  data write value.
REQ-015 d_gnt  output  1  data request accepted this cycle.
REQ-016 d_done  output  1  one-cycle pulse marking data completion.
REQ-017 d_rdata  output  DATA_W  data read value.
REQ-018 m_valid  output  1  request to the shared memory.
REQ-019 m_rnw  output  1  memory access direction.
REQ-020 m_addr  output  ADDR_W  memory address.
REQ-021 m_wdata  output  DATA_W  memory write data.
REQ-022 m_ready  input  1  memory completes the current access this cycle.
REQ-023 m_rdata  input  DATA_W  memory read data, valid when m_ready is high.
REQ-024 err  output  1  one-cycle pulse marking a timeout abort; coincides with the aborted requester's done pulse.

Function
REQ-025 The FSM SHALL have three states: IDLE, BUSY_I and BUSY_D.
REQ-026 In IDLE, i_gnt and d_gnt SHALL be combinational from state and the requests; at most one SHALL be high, and both SHALL be 0 outside IDLE.
REQ-027 In IDLE, when both requests are high, d_req SHALL win (fixed priority) unless ARB_RR_EN is defined.
REQ-028 On a granted edge the block SHALL register the winner's addr, rnw and wdata (fetch uses rnw=1, wdata=0) into m_addr/m_rnw/m_wdata, set m_valid=1 and enter BUSY_I or BUSY_D.
REQ-029 In BUSY_x, m_valid, m_addr, m_rnw and m_wdata SHALL hold stable until m_ready is sampled high.
REQ-030 On the edge where m_ready=1 in BUSY_x, the block SHALL:
- clear m_valid;
- return to IDLE;
- pulse x_done for the next cycle;
- for reads only, load x_rdata from m_rdata.
REQ-031 x_rdata SHALL hold its value until the next read completion for that requester.
REQ-032 Minimum latency: request with grant in cycle 0, m_valid in cycle 1, m_ready in cycle 1, x_done in cycle 2; a new grant is possible in cycle 2.
REQ-033 A BUSY cycle counter SHALL clear on entry to BUSY.
REQ-034 If the counter reaches TIMEOUT without m_ready, the block SHALL:
- clear m_valid;
- return to IDLE;
- pulse x_done and err together;
- leave x_rdata unchanged.
REQ-035 m_ready sampled in IDLE SHALL be ignored.
REQ-036 A requester deasserting its req after grant SHALL NOT affect the transaction in flight.
REQ-037 A write SHALL complete with x_done, and x_rdata SHALL be unchanged.

Reset
REQ-038 While reset=0 the block SHALL asynchronously enter IDLE with:
- m_valid, m_rnw, m_addr and m_wdata = 0;
- i_done, d_done and err = 0;
- i_rdata and d_rdata = 0;
- counter = 0;
- round-robin last-served flag = I.
REQ-039 Reset asserted mid-transaction SHALL abandon it with no done pulse.
REQ-040 The first grant SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-041 With macro ARB_RR_EN defined, simultaneous requests SHALL be granted to the requester not served last; the last-served flag SHALL update on every grant.
REQ-042 Without ARB_RR_EN, priority SHALL be fixed to D and no last-served flag SHALL exist.

Verification
REQ-043 Fetch read: i_req=1, i_addr=0x100; m_ready=1 one cycle after m_valid with m_rdata=0xDEADBEEF -> i_gnt in cycle 0, m_addr=0x100 and m_rnw=1 in cycle 1, i_done with i_rdata=0xDEADBEEF in cycle 2.
REQ-044 Data write: d_req=1, d_rnw=0, d_addr=0x200, d_wdata=0x1234; m_ready delayed 3 cycles -> m_valid, m_addr and m_wdata stable for 4 cycles, d_done one cycle later, d_rdata unchanged.
REQ-045 Contention: i_req and d_req both held high for 4 transactions -> without ARB_RR_EN grants are D,D,D,D; with ARB_RR_EN grants are D,I,D,I.
REQ-046 Timeout: m_ready held 0 with TIMEOUT=4 -> m_valid drops after 4 BUSY cycles, err and x_done pulse together, next request granted normally.
REQ-047 Reset mid-operation: reset=0 while in BUSY_D -> m_valid=0 immediately, no d_done, IDLE after release.
REQ-048 Stray ready: m_ready=1 in IDLE with no requests -> no done pulse, no state change.
